// File: rtl/matvec_pkg.sv
// ---------------------------------------------------------------------------
// matvec_pkg: shared constants, feeder state encoding and one-hot helper.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package matvec_pkg;

  localparam int NUM_FIFOS      = 9;
  localparam int BYTES_PER_WORD = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    WAIT_DATA = 3'd2,
    UNPACK    = 3'd3,
    DONE      = 3'd4
  } feeder_state_t;

  function automatic logic [NUM_FIFOS-1:0] onehot(input int unsigned idx);
    logic [NUM_FIFOS-1:0] sel;
    sel = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      sel[i] = (idx == unsigned'(i));
    end
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_mem_feeder_if.sv
// ---------------------------------------------------------------------------
// fifo_mem_feeder_if: Avalon-MM read master plus FIFO writer bundle.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fifo_mem_feeder_if #(
  parameter int ADDR_W    = 32,
  parameter int NUM_FIFOS = 9
);

  logic [ADDR_W-1:0]    avm_address;
  logic                 avm_read;
  logic                 avm_waitrequest;
  logic [63:0]          avm_readdata;
  logic                 avm_readdatavalid;
  logic [NUM_FIFOS-1:0] fifo_addr;
  logic [7:0]           fifo_din;
  logic                 en_fifo_write;
  logic [NUM_FIFOS-1:0] fifo_full;

  modport master (
    output avm_address, avm_read, fifo_addr, fifo_din, en_fifo_write,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid, fifo_full
  );

  modport slave (
    input  avm_address, avm_read, fifo_addr, fifo_din, en_fifo_write,
    output avm_waitrequest, avm_readdata, avm_readdatavalid, fifo_full
  );

endinterface

`default_nettype wire

// File: rtl/fifo_mem_feeder_word_unpacker.sv
// ---------------------------------------------------------------------------
// word_unpacker: 64-bit load/shift register emitting bytes LSB first.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module word_unpacker
  import matvec_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic [BYTES_PER_WORD*8-1:0] load_data,
  input  logic                        advance,
  output logic [7:0]                  byte_out,
  output logic                        last_byte
);

  localparam int WORD_W = BYTES_PER_WORD * 8;

  logic [WORD_W-1:0] word;
  logic [2:0]        byte_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (load) begin
      word     <= load_data;
      byte_cnt <= '0;
    end else if (advance) begin
      word     <= word >> 8;
      byte_cnt <= byte_cnt + 3'd1;
    end
  end

  assign byte_out  = word[7:0];
  assign last_byte = (byte_cnt == 3'(BYTES_PER_WORD - 1));

endmodule

`default_nettype wire

// File: rtl/fifo_mem_feeder.sv
// ---------------------------------------------------------------------------
// fifo_mem_feeder: reads one 64-bit word per FIFO over Avalon-MM and writes
// its bytes into the selected FIFO under full back-pressure. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_mem_feeder #(
  parameter int                ADDR_W    = 32,
  parameter int                NUM_FIFOS = 9,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill,
  input  logic              Clr,
  fifo_mem_feeder_if.master bus,
  output logic              memory_busy,
  output logic              done
);

  import matvec_pkg::*;

  localparam int               ROW_W    = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_FIFOS - 1);

  feeder_state_t        state;
  logic [ROW_W-1:0]     row;
  logic                 abort_pending;
  logic                 avm_read_q;
  logic [ADDR_W-1:0]    avm_address_q;
  logic [NUM_FIFOS-1:0] row_sel;
  logic                 write;
  logic                 load;
  logic                 last_byte;
  logic [7:0]           byte_out;

  for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_row_sel
    assign row_sel[i] = (row == ROW_W'(i));
  end

  // The write strobe follows fifo_full combinationally so a FIFO that fills
  // on this very byte can never take an extra write; Clr suppresses it too.
  assign write = (state == UNPACK) && !bus.fifo_full[row] && !Clr;
  assign load  = (state == WAIT_DATA) && bus.avm_readdatavalid && !abort_pending && !Clr;

  word_unpacker u_unpacker (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (bus.avm_readdata),
    .advance   (write),
    .byte_out  (byte_out),
    .last_byte (last_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      row           <= '0;
      abort_pending <= 1'b0;
      avm_read_q    <= 1'b0;
      avm_address_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fill && !Clr) begin
            row           <= '0;
            avm_address_q <= BASE_ADDR;
            avm_read_q    <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          if (Clr) abort_pending <= 1'b1;
          if (!bus.avm_waitrequest) begin
            avm_read_q <= 1'b0;
            state      <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          // An aborted read still waits for its data so the slave stays in sync.
          if (bus.avm_readdatavalid) begin
            abort_pending <= 1'b0;
            state         <= (abort_pending || Clr) ? IDLE : UNPACK;
          end else if (Clr) begin
            abort_pending <= 1'b1;
          end
        end
        UNPACK: begin
          if (Clr) begin
            state <= IDLE;
          end else if (write && last_byte) begin
            if (row == LAST_ROW) begin
              state <= DONE;
            end else begin
              row           <= row + ROW_W'(1);
              avm_address_q <= BASE_ADDR + ADDR_W'(row) + ADDR_W'(1);
              avm_read_q    <= 1'b1;
              state         <= REQ;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.avm_read      = avm_read_q;
  assign bus.avm_address   = avm_address_q;
  assign bus.en_fifo_write = write;
  assign bus.fifo_addr     = write ? row_sel : '0;
  assign bus.fifo_din      = write ? byte_out : 8'h00;
  assign memory_busy       = (state != IDLE);
  assign done              = (state == DONE) && !Clr;

endmodule

`default_nettype wire

// File: tb/tb_fifo_mem_feeder.sv
// ---------------------------------------------------------------------------
// tb_fifo_mem_feeder: directed bench with an Avalon slave model and write log.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fifo_mem_feeder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic fill  = 1'b0;
  logic Clr   = 1'b0;
  logic memory_busy;
  logic done;

  fifo_mem_feeder_if #(.ADDR_W(32), .NUM_FIFOS(9)) bus ();

  fifo_mem_feeder #(.ADDR_W(32), .NUM_FIFOS(9), .BASE_ADDR(32'd0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fill        (fill),
    .Clr         (Clr),
    .bus         (bus),
    .memory_busy (memory_busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [8:0]  wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  logic [31:0] rd_addr_q[$];
  int          done_cnt     = 0;
  int          a2_cycles    = 0;
  int          stall_writes = 0;
  int          stall_left   = 0;
  logic [31:0] stall_addr   = 32'hFFFF_FFFF;
  int          lat          = 0;
  logic [31:0] lat_addr     = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return 64'h0807060504030201 + 64'(a) * 64'h0808080808080808;
  endfunction

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    done_cnt     = 0;
    a2_cycles    = 0;
    stall_writes = 0;
  endtask

  task automatic wait_writes(input int target, input string tag);
    int n = 0;
    while (wr_addr_q.size() < target && n < 2000) begin
      tick();
      n++;
    end
    if (wr_addr_q.size() < target) check_val({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 2000) begin
      tick();
      n++;
    end
    if (done_cnt == 0) check_val({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  // Expected write k: byte value k+1, FIFO k/8.
  task automatic check_full_run(input string tag);
    int bad = 0;
    check_val({tag, "_writes"}, 64'(wr_addr_q.size()), 64'd72);
    check_val({tag, "_reads"}, 64'(rd_addr_q.size()), 64'd9);
    for (int k = 0; k < wr_addr_q.size() && k < 72; k++) begin
      if (wr_data_q[k] !== 8'(k + 1) || wr_addr_q[k] !== (9'd1 << (k / 8))) bad++;
    end
    check_val({tag, "_wr_seq_bad"}, 64'(bad), 64'd0);
    bad = 0;
    for (int i = 0; i < rd_addr_q.size(); i++) begin
      if (rd_addr_q[i] !== 32'(i)) bad++;
    end
    check_val({tag, "_rd_addr_bad"}, 64'(bad), 64'd0);
    check_val({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
  endtask

  // Slave model and observer: one read at a time, data two cycles after accept.
  initial begin
    bus.avm_waitrequest   = 1'b0;
    bus.avm_readdata      = '0;
    bus.avm_readdatavalid = 1'b0;
    forever begin
      @(negedge clk);
      bus.avm_readdatavalid = 1'b0;
      if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          bus.avm_readdatavalid = 1'b1;
          bus.avm_readdata      = mem_word(lat_addr);
        end
      end
      if (bus.avm_read) begin
        if (bus.avm_address == 32'd2) a2_cycles++;
        if (stall_left > 0 && bus.avm_address == stall_addr) begin
          bus.avm_waitrequest = 1'b1;
          stall_left--;
        end else begin
          bus.avm_waitrequest = 1'b0;
          rd_addr_q.push_back(bus.avm_address);
          lat      = 2;
          lat_addr = bus.avm_address;
        end
      end else begin
        bus.avm_waitrequest = 1'b0;
      end
      if (bus.en_fifo_write) begin
        wr_addr_q.push_back(bus.fifo_addr);
        wr_data_q.push_back(bus.fifo_din);
        if (bus.fifo_full != '0) stall_writes++;
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    int n;
    int row4;
    bus.fifo_full = '0;
    repeat (3) tick();
    check_val("rst_busy", 64'(memory_busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_avm_read", 64'(bus.avm_read), 64'd0);
    check_val("rst_avm_address", 64'(bus.avm_address), 64'd0);
    check_val("rst_en_write", 64'(bus.en_fifo_write), 64'd0);
    check_val("rst_fifo_addr", 64'(bus.fifo_addr), 64'd0);
    rst_n = 1'b1;
    tick();

    // Clr and fill together in IDLE: Clr wins.
    fill = 1'b1; Clr = 1'b1;
    tick();
    fill = 1'b0; Clr = 1'b0;
    check_val("clrfill_busy", 64'(memory_busy), 64'd0);
    check_val("clrfill_read", 64'(bus.avm_read), 64'd0);
    tick();
    check_val("clrfill_no_reads", 64'(rd_addr_q.size()), 64'd0);

    // Plain nine-row fill.
    clear_log();
    fill = 1'b1;
    tick();
    fill = 1'b0;
    check_val("t1_first_read", 64'(bus.avm_read), 64'd1);
    check_val("t1_first_addr", 64'(bus.avm_address), 64'd0);
    wait_done("t1");
    tick();
    check_val("t1_busy_after", 64'(memory_busy), 64'd0);
    repeat (3) tick();
    check_full_run("t1");
    check_val("t1_w0_data", 64'(wr_data_q[0]), 64'h01);
    check_val("t1_w0_addr", 64'(wr_addr_q[0]), 64'h001);
    check_val("t1_w7_data", 64'(wr_data_q[7]), 64'h08);
    check_val("t1_w64_data", 64'(wr_data_q[64]), 64'h41);
    check_val("t1_w71_addr", 64'(wr_addr_q[71]), 64'h100);
    check_val("t1_w71_data", 64'(wr_data_q[71]), 64'h48);

    // Waitrequest stall on row 2, full stall on row 4, stray fill on row 5.
    clear_log();
    stall_addr = 32'd2;
    stall_left = 3;
    fill = 1'b1;
    tick();
    fill = 1'b0;
    wait_writes(36, "t3_row4_b3");
    @(posedge clk); #1;
    bus.fifo_full = 9'h010;
    repeat (5) @(posedge clk);
    #1;
    bus.fifo_full = '0;
    wait_writes(42, "t4_row5");
    fill = 1'b1;
    tick();
    fill = 1'b0;
    wait_done("t2");
    repeat (3) tick();
    check_val("t2_busy_after", 64'(memory_busy), 64'd0);
    check_val("t2_addr2_read_cycles", 64'(a2_cycles), 64'd4);
    n = 0;
    foreach (rd_addr_q[i]) if (rd_addr_q[i] == 32'd2) n++;
    check_val("t2_addr2_accepts", 64'(n), 64'd1);
    check_val("t3_writes_while_full", 64'(stall_writes), 64'd0);
    row4 = 0;
    foreach (wr_addr_q[i]) if (wr_addr_q[i] == 9'h010) row4++;
    check_val("t3_row4_writes", 64'(row4), 64'd8);
    check_full_run("t2");

    // Clr while row 3 read is outstanding.
    clear_log();
    fill = 1'b1;
    tick();
    fill = 1'b0;
    n = 0;
    while (!(bus.avm_read && bus.avm_address == 32'd3 && !bus.avm_waitrequest) && n < 2000) begin
      tick();
      n++;
    end
    check_val("t5_row3_req_seen", 64'(n < 2000), 64'd1);
    tick();
    Clr = 1'b1;
    check_val("t5_busy_wait0", 64'(memory_busy), 64'd1);
    tick();
    Clr = 1'b0;
    check_val("t5_busy_wait1", 64'(memory_busy), 64'd1);
    tick();
    check_val("t5_idle_after_rdv", 64'(memory_busy), 64'd0);
    repeat (3) tick();
    check_val("t5_writes", 64'(wr_addr_q.size()), 64'd24);
    check_val("t5_done_pulses", 64'(done_cnt), 64'd0);
    clear_log();
    fill = 1'b1;
    tick();
    fill = 1'b0;
    check_val("t5_restart_read", 64'(bus.avm_read), 64'd1);
    check_val("t5_restart_addr", 64'(bus.avm_address), 64'd0);
    wait_done("t5");
    repeat (3) tick();
    check_full_run("t5");

    // Async reset during row 1 byte 5.
    clear_log();
    fill = 1'b1;
    tick();
    fill = 1'b0;
    wait_writes(13, "t6_row1_b4");
    tick();
    check_val("t6_pre_en", 64'(bus.en_fifo_write), 64'd1);
    check_val("t6_pre_din", 64'(bus.fifo_din), 64'h0E);
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_en", 64'(bus.en_fifo_write), 64'd0);
    check_val("t6_rst_fifo_addr", 64'(bus.fifo_addr), 64'd0);
    check_val("t6_rst_read", 64'(bus.avm_read), 64'd0);
    check_val("t6_rst_busy", 64'(memory_busy), 64'd0);
    check_val("t6_rst_done", 64'(done), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    clear_log();
    fill = 1'b1;
    tick();
    fill = 1'b0;
    wait_done("t6");
    repeat (3) tick();
    check_full_run("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_mem_feeder.md
Name: fifo_mem_feeder

Overview:
Memory-side producer for the matrix-vector multiplier's nine input FIFOs (8 matrix-row FIFOs plus 1 vector FIFO).
- On a fill request, issues one Avalon-MM read per FIFO and unpacks each 64-bit word into 8 bytes.
- Writes the bytes into the FIFO selected by a one-hot address, honouring per-FIFO full back-pressure.
- Acts as the writer end of the FIFO interface that the multiplier's control FSM drains.

Parameters:
ADDR_W, 32, Avalon address width (word addressing).
NUM_FIFOS, 9, number of destination FIFOs; index NUM_FIFOS-1 is the vector FIFO.
BASE_ADDR, 0, word address of row 0; row r is at BASE_ADDR+r.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
fill  in  1  start request, sampled only in IDLE
Clr  in  1  synchronous abort
avm_address  out  ADDR_W  read address
avm_read  out  1  read request
avm_waitrequest  in  1  slave stall
avm_readdata  in  64  read data
avm_readdatavalid  in  1  read data valid
fifo_addr  out  NUM_FIFOS  one-hot FIFO select; 0 when not writing
fifo_din  out  8  byte to FIFO
en_fifo_write  out  1  FIFO write strobe
fifo_full  in  NUM_FIFOS  per-FIFO full flags
memory_busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse when all FIFOs are loaded

Behaviour:
- Reset (async): state=IDLE, row=0, byte_cnt=0, word register=0, abort_pending=0. All outputs are 0.
- States are IDLE, REQ, WAIT_DATA, UNPACK, DONE.
- IDLE:
  - fill=1 -> row=0, next state REQ.
  - fill in any other state is ignored.
- REQ:
  - avm_read=1, avm_address=BASE_ADDR+row.
  - Both are held stable while avm_waitrequest=1.
  - The first cycle with avm_waitrequest=0 completes the command -> WAIT_DATA.
  - Exactly one read is outstanding at a time.
- WAIT_DATA:
  - avm_read=0.
  - On avm_readdatavalid, capture avm_readdata, set byte_cnt=0 -> UNPACK.
  - Readdatavalid seen outside WAIT_DATA is ignored.
- UNPACK:
  - Each cycle with fifo_full[row]=0: en_fifo_write=1, fifo_din=word[7:0], fifo_addr=1<<row. Then word>>=8 and byte_cnt++.
  - Byte order is little-endian: byte 0 = readdata[7:0] is written first.
  - While fifo_full[row]=1: en_fifo_write=0, no state change. No byte is lost or duplicated.
  - After byte 7 is written: if row==NUM_FIFOS-1 -> DONE, else row++ -> REQ.
- DONE: done=1 for exactly one cycle, then -> IDLE.
- Write rules:
  - en_fifo_write and fifo_addr are asserted only in UNPACK and only on non-full cycles.
  - fifo_addr is always one-hot or zero.
- Throughput: the minimum per row is 1 REQ cycle, plus the slave read latency, plus 8 UNPACK cycles. The first avm_read rises the cycle after fill is sampled.
- Clr handling:
  - Clr in IDLE, UNPACK or DONE: next state IDLE, no further writes, no done pulse.
  - Clr in REQ or WAIT_DATA: set abort_pending. The Avalon read is completed per protocol (address and read are held until waitrequest drops, then readdatavalid is awaited). The returned data is discarded and the block goes to IDLE. No FIFO writes occur and done is not pulsed.
  - Clr with fill in the same IDLE cycle: Clr wins, so the block stays in IDLE.
- Async rst_n mid-operation returns the block to the reset state immediately. Recovering the Avalon slave is the system's responsibility.
- Widths:
  - row is ceil(log2(NUM_FIFOS)) bits; byte_cnt is 3 bits.
  - avm_address is computed modulo 2^ADDR_W, so it wraps with no error.

Decomposition:
- Shared package matvec_pkg:
  - NUM_FIFOS and BYTES_PER_WORD=8.
  - The feeder state enum typedef (IDLE, REQ, WAIT_DATA, UNPACK, DONE).
  - The one-hot helper function.
- Optional sub-module word_unpacker: a 64-bit load/shift register with byte_cnt and a last_byte flag, advanced by a write-accept signal. The FSM and Avalon logic stay in the top level.

Test Plan:
1. Memory row r = 0x0807060504030201 + r*0x0808080808080808, waitrequest=0, readdatavalid 2 cycles after the command, fifo_full=0 -> 9 reads at addresses 0..8 and 72 writes. Row 0 bytes arrive in order 01..08 with fifo_addr=9'h001; the last row has fifo_addr=9'h100. One done pulse, then memory_busy=0.
2. avm_waitrequest held high 3 cycles on row 2 -> avm_read=1 and avm_address=2 stable for 4 cycles, exactly one read accepted, data correct.
3. fifo_full[4] high for 5 cycles after byte 3 of row 4 -> no writes during the stall, then bytes 4..7 resume in order. Row 4 receives exactly 8 writes.
4. fill pulsed again during row 5 -> ignored. Total reads=9, done pulses=1.
5. Clr asserted in WAIT_DATA on row 3, readdatavalid 2 cycles later -> zero writes for row 3, IDLE the cycle after readdatavalid, no done. A new fill restarts at address 0.
6. rst_n asserted during UNPACK byte 5 -> en_fifo_write, fifo_addr, avm_read, memory_busy and done all 0 immediately. A fill after reset release runs a full 9-row sequence.
